// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared helpers and default parameter values for the multi-channel debounce controller.
package debounce_scan_ctrl_pkg;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_NUM_STAGES   = 2;
    localparam int DEF_TICK_DIV     = 100;
    localparam int DEF_STABLE_TICKS = 8;

    // Edge polarity carried with each event.
    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width for a counter holding 0..count-1, never narrower than one bit.
    function automatic int width_of(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, tick-driven stability counter and
// the pending/polarity/overrun bookkeeping for the event it produces.
module debounce_channel
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = DEF_NUM_STAGES,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic srst,
    input  logic noisy,
    input  logic tick,
    input  logic grant_clr,
    input  logic overrun_clr,
    output logic debounced,
    output logic pending,
    output logic pol,
    output logic overrun
);

    localparam int              CNT_W    = width_of(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [NUM_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  debounced_reg;
    logic                  pending_reg;
    logic                  pol_reg;
    logic                  overrun_reg;
    logic                  sync_level;
    logic                  accept;

    assign sync_level = sync_reg[NUM_STAGES-1];
    // A new level is taken on the tick where the mismatch has already lasted STABLE_TICKS-1 ticks.
    assign accept     = tick && (sync_level != debounced_reg) && (cnt_reg == CNT_LAST);

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[NUM_STAGES-2:0], noisy};
        end
    end

    // Count consecutive mismatching tick samples and adopt the new level when stable.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg       <= '0;
            debounced_reg <= 1'b0;
        end else if (tick) begin
            if (sync_level == debounced_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                debounced_reg <= sync_level;
                cnt_reg       <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Track the unreported edge; a fresh edge beats the arbiter's clear, and
    // overwriting a still-pending edge (one not just granted) flags overrun.
    always_ff @(posedge clk) begin
        if (srst) begin
            pending_reg <= 1'b0;
            pol_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                pending_reg <= 1'b1;
                pol_reg     <= sync_level;
            end else if (grant_clr) begin
                pending_reg <= 1'b0;
            end
            if (accept && pending_reg && !grant_clr) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign debounced = debounced_reg;
    assign pending   = pending_reg;
    assign pol       = pol_reg;
    assign overrun   = overrun_reg;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debounce controller: shared sample-tick prescaler, NUM_CH
// debounce channels, round-robin arbiter and a single valid/ready event register.
module debounce_scan_ctrl
    import debounce_scan_ctrl_pkg::*;
#(
    parameter  int NUM_CH       = DEF_NUM_CH,
    parameter  int NUM_STAGES   = DEF_NUM_STAGES,
    parameter  int TICK_DIV     = DEF_TICK_DIV,
    parameter  int STABLE_TICKS = DEF_STABLE_TICKS,
    localparam int CH_W         = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] noisy_in,
    output logic [NUM_CH-1:0] debounced_out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic [NUM_CH-1:0] overrun,
    input  logic [NUM_CH-1:0] overrun_clr
);

    localparam int             PS_W    = width_of(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    // Elaboration-time guards on the parameter ranges the logic relies on.
    if (NUM_CH < 2) begin : g_chk_num_ch
        $error("debounce_scan_ctrl: NUM_CH must be >= 2");
    end
    if (NUM_STAGES < 2) begin : g_chk_num_stages
        $error("debounce_scan_ctrl: NUM_STAGES must be >= 2");
    end
    if (TICK_DIV < 1) begin : g_chk_tick_div
        $error("debounce_scan_ctrl: TICK_DIV must be >= 1");
    end
    if (STABLE_TICKS < 2) begin : g_chk_stable_ticks
        $error("debounce_scan_ctrl: STABLE_TICKS must be >= 2");
    end

    logic [PS_W-1:0]   ps_reg;
    logic              tick;
    logic [NUM_CH-1:0] debounced_vec;
    logic [NUM_CH-1:0] pending_vec;
    logic [NUM_CH-1:0] pol_vec;
    logic [NUM_CH-1:0] overrun_vec;
    logic [NUM_CH-1:0] grant_clr_vec;
    logic              evt_valid_reg;
    logic [CH_W-1:0]   evt_ch_reg;
    logic              evt_rise_reg;
    logic [CH_W-1:0]   last_grant_reg;
    logic              load;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    int                scan_idx;

    assign tick = (ps_reg == PS_LAST);
    // The event register may take a new event whenever it is empty or being drained.
    assign load = !evt_valid_reg || evt_ready;

    // Free-running sample prescaler, wrapping at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_reg <= '0;
        end else if (tick) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_reg + PS_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign grant_clr_vec[gi] = load && grant_found && (grant_idx == CH_W'(gi));

        debounce_channel #(
            .NUM_STAGES   (NUM_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_channel (
            .clk         (clk),
            .srst        (rst),
            .noisy       (noisy_in[gi]),
            .tick        (tick),
            .grant_clr   (grant_clr_vec[gi]),
            .overrun_clr (overrun_clr[gi]),
            .debounced   (debounced_vec[gi]),
            .pending     (pending_vec[gi]),
            .pol         (pol_vec[gi]),
            .overrun     (overrun_vec[gi])
        );
    end

    // Round-robin search: first pending channel after the last one granted, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = (int'(last_grant_reg) + k) % NUM_CH;
            if (!grant_found && pending_vec[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(scan_idx);
            end
        end
    end

    // Event register: refill from the arbiter on each load opportunity, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_reg  <= 1'b0;
            evt_ch_reg     <= '0;
            evt_rise_reg   <= 1'b0;
            last_grant_reg <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            evt_valid_reg <= grant_found;
            if (grant_found) begin
                evt_ch_reg     <= grant_idx;
                evt_rise_reg   <= pol_vec[grant_idx];
                last_grant_reg <= grant_idx;
            end
        end
    end

    assign debounced_out = debounced_vec;
    assign overrun       = overrun_vec;
    assign evt_valid     = evt_valid_reg;
    assign evt_ch        = evt_ch_reg;
    assign evt_rise      = evt_rise_reg;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Scoreboard bench for debounce_scan_ctrl: directed stimulus pushes expected
// events; a negedge monitor pops and compares on every accepted handshake.
module tb_debounce_scan_ctrl;

    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] noisy_in;
    logic [NUM_CH-1:0] debounced_out;
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_ch;
    logic              evt_rise;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] overrun_clr;

    int   checks;
    int   fails;
    int   cyc;
    exp_t sb_q[$];
    int   hs_q[$];
    exp_t mon_exp;

    debounce_scan_ctrl #(
        .NUM_CH       (4),
        .NUM_STAGES   (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noisy_in      (noisy_in),
        .debounced_out (debounced_out),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_ch        (evt_ch),
        .evt_rise      (evt_rise),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            hs_q.push_back(cyc);
            checks++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL evt_unexpected: got ch=%0d rise=%0d, required no event", evt_ch, evt_rise);
            end else begin
                mon_exp = sb_q.pop_front();
                if (evt_ch !== mon_exp.ch || evt_rise !== mon_exp.rise) begin
                    fails++;
                    $display("FAIL evt_compare: got ch=%0d rise=%0d, required ch=%0d rise=%0d",
                             evt_ch, evt_rise, mon_exp.ch, mon_exp.rise);
                end else begin
                    $display("evt accepted ch=%0d rise=%0d at cycle %0d", evt_ch, evt_rise, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic push(input int ch, input logic rise);
        exp_t e;
        e.ch   = 2'(ch);
        e.rise = rise;
        sb_q.push_back(e);
    endtask

    task automatic wait_deb(input logic [3:0] target, input int budget, input string name, output int n);
        n = 0;
        while (debounced_out !== target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(debounced_out), 32'(target));
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        bit bad;
        checks      = 0;
        fails       = 0;
        cyc         = 0;
        rst         = 1'b1;
        noisy_in    = 4'hF;
        evt_ready   = 1'b1;
        overrun_clr = 4'h0;

        // 1: reset with all inputs high, then power-up debounce of all four
        step();
        step();
        check("reset_debounced", 32'(debounced_out), 32'h0);
        check("reset_evt_valid", 32'(evt_valid), 32'h0);
        check("reset_evt_ch", 32'(evt_ch), 32'h0);
        check("reset_evt_rise", 32'(evt_rise), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        for (int c = 0; c < 4; c++) push(c, 1'b1);
        rst = 1'b0;
        wait_deb(4'hF, 20, "powerup_debounced", n);
        check("powerup_within_14", 32'(n <= 14), 32'd1);
        wait_empty(20, "powerup_events_drained");

        // all inputs low: four releases, channel 0 first because channel 3 was granted last
        for (int c = 0; c < 4; c++) push(c, 1'b0);
        noisy_in = 4'h0;
        wait_deb(4'h0, 20, "release_all_debounced", n);
        wait_empty(20, "release_all_drained");

        // 2: a 6-clock glitch on channel 0 never reaches the output
        noisy_in[0] = 1'b1;
        repeat (6) step();
        noisy_in[0] = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (debounced_out[0] !== 1'b0 || evt_valid !== 1'b0) bad = 1'b1;
        end
        check("glitch_rejected", 32'(bad), 32'd0);

        // 3: clean press on channel 1 with the consumer stalled
        evt_ready   = 1'b0;
        push(1, 1'b1);
        noisy_in[1] = 1'b1;
        wait_deb(4'b0010, 20, "press1_debounced", n);
        check("press1_latency_10_14", 32'(n >= 10 && n <= 14), 32'd1);
        step();
        check("press1_evt_valid", 32'(evt_valid), 32'd1);
        check("press1_evt_ch", 32'(evt_ch), 32'd1);
        check("press1_evt_rise", 32'(evt_rise), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_rise !== 1'b1) bad = 1'b1;
        end
        check("press1_held_stable", 32'(bad), 32'd0);
        evt_ready = 1'b1;
        step();
        check("press1_accepted_valid_low", 32'(evt_valid), 32'd0);
        check("press1_scoreboard_empty", 32'(sb_q.size()), 32'd0);

        // press and release channel 3 so the last grant is channel 3
        push(3, 1'b1);
        noisy_in[3] = 1'b1;
        wait_deb(4'b1010, 20, "ch3_press_debounced", n);
        push(3, 1'b0);
        noisy_in[3] = 1'b0;
        wait_deb(4'b0010, 20, "ch3_release_debounced", n);
        wait_empty(20, "ch3_events_drained");

        // 4: round robin, ch0/ch2/ch3 together, back-to-back
        hs_q.delete();
        push(0, 1'b1);
        push(2, 1'b1);
        push(3, 1'b1);
        noisy_in = 4'b1111;
        wait_deb(4'b1111, 20, "rr_debounced", n);
        n = 0;
        while (hs_q.size() < 3 && n < 20) begin
            step();
            n++;
        end
        check("rr_three_events", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() >= 3) begin
            check("rr_consecutive_1", 32'(hs_q[1] - hs_q[0]), 32'd1);
            check("rr_consecutive_2", 32'(hs_q[2] - hs_q[1]), 32'd1);
        end
        // ch0 + ch3 released together after ch3 was granted: ch0 first
        push(0, 1'b0);
        push(3, 1'b0);
        noisy_in = 4'b0110;
        wait_deb(4'b0110, 20, "rr_pair_debounced", n);
        wait_empty(20, "rr_pair_drained");

        // 5: overrun on channel 2
        push(2, 1'b0);
        noisy_in = 4'b0010;
        wait_deb(4'b0010, 20, "ch2_release_debounced", n);
        wait_empty(20, "ch2_release_drained");
        evt_ready = 1'b0;
        push(2, 1'b1);
        push(2, 1'b1);
        noisy_in[2] = 1'b1;
        repeat (20) step();
        noisy_in[2] = 1'b0;
        repeat (20) step();
        noisy_in[2] = 1'b1;
        repeat (20) step();
        check("ovr_debounced", 32'(debounced_out), 32'b0110);
        check("ovr_overrun_set", 32'(overrun), 32'b0100);
        check("ovr_held_valid", 32'(evt_valid), 32'd1);
        check("ovr_held_ch", 32'(evt_ch), 32'd2);
        check("ovr_held_rise", 32'(evt_rise), 32'd1);
        evt_ready = 1'b1;
        wait_empty(10, "ovr_events_drained");
        check("ovr_overrun_sticky", 32'(overrun), 32'b0100);
        overrun_clr = 4'b0100;
        step();
        overrun_clr = 4'b0000;
        check("ovr_overrun_cleared", 32'(overrun), 32'd0);

        // 6: mid-operation reset with three edges outstanding
        evt_ready = 1'b0;
        noisy_in  = 4'b1101;
        wait_deb(4'b1101, 20, "mid_debounced", n);
        step();
        step();
        check("mid_evt_held", 32'(evt_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_evt_valid", 32'(evt_valid), 32'd0);
        check("mid_reset_debounced", 32'(debounced_out), 32'd0);
        check("mid_reset_overrun", 32'(overrun), 32'd0);
        evt_ready = 1'b1;
        push(0, 1'b1);
        push(2, 1'b1);
        push(3, 1'b1);
        wait_deb(4'b1101, 20, "mid_redebounced", n);
        wait_empty(20, "mid_events_drained");
        repeat (20) step();
        check("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
